// File: rtl/sl_tx_scheduler_if.sv
// Requester and transmitter register-port signals of the SL transmit scheduler.
// The scheduler takes the master side; the requesters and transmitter sit on the slave side.
interface sl_tx_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_data;
    logic [6*NREQ-1:0]    req_len;
    logic [3*NREQ-1:0]    req_freq;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_done;
    logic [NREQ-1:0]      req_err;
    logic [31:0]          tx_d_in;
    logic                 tx_wr_en;
    logic                 tx_addr;
    logic [31:0]          tx_d_out;
    logic                 busy;
    logic [2:0]           grant_id;

    modport master (
        input  req_valid, req_data, req_len, req_freq, tx_d_out,
        output req_ready, req_done, req_err, tx_d_in, tx_wr_en, tx_addr, busy, grant_id
    );

    modport slave (
        output req_valid, req_data, req_len, req_freq, tx_d_out,
        input  req_ready, req_done, req_err, tx_d_in, tx_wr_en, tx_addr, busy, grant_id
    );
endinterface

// File: rtl/sl_tx_scheduler.sv
// Round-robin scheduler sharing one SL transmitter among NREQ requesters: programs config
// (cached), writes data, polls status, acknowledges completion and reports done/err.
//
// state    | meaning
// S_IDLE   | no work, waiting for any req_valid
// S_ARB    | pick next requester, pulse req_ready, capture request
// S_CFG    | write config word (skipped on cache hit)
// S_DATA   | write message word, clear poll counter
// S_SETTLE | select status register, read data not yet valid
// S_POLL   | sample status until complete or timeout
// S_ACK    | write back captured status with complete flag cleared
// S_DONE   | pulse req_done for the owner
// S_ERR    | pulse req_err for the owner
module sl_tx_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               rst,
    sl_tx_scheduler_if.master  io_bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_ARB, S_CFG, S_DATA, S_SETTLE, S_POLL, S_ACK, S_DONE, S_ERR
    } state_t;

    localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_last_grant;
    logic [2:0]  r_grant;
    logic [31:0] r_data;
    logic [5:0]  r_len;
    logic [2:0]  r_freq;
    logic [31:0] r_status;
    logic [15:0] r_cnt;
    logic        r_cache_vld;
    logic [5:0]  r_cache_len;
    logic [2:0]  r_cache_freq;

    logic [31:0] w_data_arr [8];
    logic [5:0]  w_len_arr  [8];
    logic [2:0]  w_freq_arr [8];
    logic [7:0]  w_valid8;
    logic        w_found;
    logic [2:0]  w_sel;
    logic [3:0]  w_sum;
    logic [31:0] w_sel_data;
    logic [5:0]  w_sel_len;
    logic [2:0]  w_sel_freq;
    logic        w_legal;
    logic        w_hit;
    logic        w_cmpl;
    logic [15:0] w_cnt_inc;
    logic        w_timeout;
    logic [7:0]  w_ready8;
    logic [7:0]  w_owner8;

    // Pad the per-requester slices out to 8 entries so a 3-bit index never runs off the end.
    for (genvar g = 0; g < 8; g++) begin : g_unpack
        if (g < NREQ) begin : g_used
            assign w_data_arr[g] = io_bus.req_data[32*g +: 32];
            assign w_len_arr[g]  = io_bus.req_len[6*g +: 6];
            assign w_freq_arr[g] = io_bus.req_freq[3*g +: 3];
            assign w_valid8[g]   = io_bus.req_valid[g];
        end else begin : g_unused
            assign w_data_arr[g] = '0;
            assign w_len_arr[g]  = '0;
            assign w_freq_arr[g] = '0;
            assign w_valid8[g]   = 1'b0;
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_sum = {1'b0, r_last_grant} + 4'(k);
            if (w_sum >= 4'(NREQ)) begin
                w_sum = w_sum - 4'(NREQ);
            end
            if (!w_found && w_valid8[w_sum[2:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[2:0];
            end
        end
    end

    assign w_sel_data = w_data_arr[w_sel];
    assign w_sel_len  = w_len_arr[w_sel];
    assign w_sel_freq = w_freq_arr[w_sel];
    assign w_legal    = !w_sel_len[0] && (w_sel_len >= 6'd8) && (w_sel_len <= 6'd32)
                        && (w_sel_freq <= 3'd5);
    assign w_hit      = r_cache_vld && (w_sel_len == r_cache_len) && (w_sel_freq == r_cache_freq);
    assign w_cmpl     = io_bus.tx_d_out[24] && !io_bus.tx_d_out[16];
    assign w_cnt_inc  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign w_timeout  = (w_cnt_inc == TO_CNT);
    assign w_ready8   = 8'd1 << w_sel;
    assign w_owner8   = 8'd1 << r_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        io_bus.req_ready = '0;
        io_bus.req_done  = '0;
        io_bus.req_err   = '0;
        io_bus.tx_d_in   = '0;
        io_bus.tx_wr_en  = 1'b0;
        io_bus.tx_addr   = 1'b0;
        io_bus.busy      = (r_state != S_IDLE);
        io_bus.grant_id  = r_grant;
        case (r_state)
            S_IDLE: begin
                if (|io_bus.req_valid) begin
                    w_next = S_ARB;
                end
            end
            S_ARB: begin
                if (!w_found) begin
                    w_next = S_IDLE;
                end else begin
                    io_bus.req_ready = w_ready8[NREQ-1:0];
                    io_bus.grant_id  = w_sel;
                    if (!w_legal) begin
                        w_next = S_ERR;
                    end else if (w_hit) begin
                        w_next = S_DATA;
                    end else begin
                        w_next = S_CFG;
                    end
                end
            end
            S_CFG: begin
                io_bus.tx_wr_en = 1'b1;
                io_bus.tx_addr  = 1'b1;
                io_bus.tx_d_in  = {22'd0, r_freq, 1'b0, r_len};
                w_next          = S_DATA;
            end
            S_DATA: begin
                io_bus.tx_wr_en = 1'b1;
                io_bus.tx_d_in  = r_data;
                w_next          = S_SETTLE;
            end
            S_SETTLE: begin
                io_bus.tx_addr = 1'b1;
                w_next         = S_POLL;
            end
            S_POLL: begin
                io_bus.tx_addr = 1'b1;
                if (w_cmpl) begin
                    w_next = S_ACK;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_ACK: begin
                io_bus.tx_wr_en = 1'b1;
                io_bus.tx_addr  = 1'b1;
                io_bus.tx_d_in  = {r_status[31:25], 1'b0, r_status[23:0]};
                w_next          = S_DONE;
            end
            S_DONE: begin
                io_bus.req_done = w_owner8[NREQ-1:0];
                w_next          = S_IDLE;
            end
            S_ERR: begin
                io_bus.req_err = w_owner8[NREQ-1:0];
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 3'(NREQ - 1);
            r_grant      <= '0;
            r_data       <= '0;
            r_len        <= '0;
            r_freq       <= '0;
            r_status     <= '0;
            r_cnt        <= '0;
            r_cache_vld  <= 1'b0;
            r_cache_len  <= '0;
            r_cache_freq <= '0;
        end else begin
            case (r_state)
                S_ARB: begin
                    if (w_found) begin
                        r_last_grant <= w_sel;
                        r_grant      <= w_sel;
                        r_data       <= w_sel_data;
                        r_len        <= w_sel_len;
                        r_freq       <= w_sel_freq;
                    end
                end
                S_CFG: begin
                    r_cache_vld  <= 1'b1;
                    r_cache_len  <= r_len;
                    r_cache_freq <= r_freq;
                end
                S_DATA: r_cnt <= '0;
                S_POLL: begin
                    r_cnt    <= w_cnt_inc;
                    r_status <= io_bus.tx_d_out;
                    // An abandoned message leaves the transmitter in an unknown state.
                    if (!w_cmpl && w_timeout) begin
                        r_cache_vld <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
